// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes,
// tag pass-through, flush and overflow/zero flags.
module alu_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_op_i,
  input  logic [XLEN-1:0]  alu_a_i,
  input  logic [XLEN-1:0]  alu_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_p_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_SRA  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_MINU = 4'd11;
  localparam logic [3:0] OP_MIN  = 4'd12;
  localparam logic [3:0] OP_MAXU = 4'd13;
  localparam logic [3:0] OP_MAX  = 4'd14;

  localparam int MSB = XLEN - 1;
  localparam logic [SHW-1:0] LO_MASK = SHW'(7);

  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_fire;
  logic             s2_load;

  logic [3:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [XLEN-1:0]  s1_sum;
  logic [XLEN-1:0]  s1_sh;

  logic [2:0]       amt_lo;
  logic [XLEN-1:0]  sum_d;
  logic [XLEN-1:0]  sh1_d;

  logic [SHW-1:0]   amt_hi;
  logic [XLEN-1:0]  sh2;
  logic             lt_s;
  logic             lt_u;
  logic             gt_s;
  logic             gt_u;
  logic             add_ovf;
  logic             sub_ovf;
  logic [XLEN-1:0]  res;
  logic             ovf_d;

  assign s2_adv      = !s2_valid || out_ready_i;
  assign in_ready_o  = !flush_i && (!s1_valid || s2_adv);
  assign in_fire     = in_valid_i && in_ready_o;
  assign s2_load     = s1_valid && s2_adv && !flush_i;
  assign out_valid_o = s2_valid;

  // Stage 1: add/sub and the fine (0..7) part of the shift
  assign amt_lo = alu_b_i[2:0];
  assign sum_d  = (alu_op_i == OP_SUB) ? alu_a_i - alu_b_i
                                       : alu_a_i + alu_b_i;

  always_comb begin
    sh1_d = alu_a_i;
    case (alu_op_i)
      OP_SLL:  sh1_d = alu_a_i << amt_lo;
      OP_SRL:  sh1_d = alu_a_i >> amt_lo;
      OP_SRA:  sh1_d = $signed(alu_a_i) >>> amt_lo;
      default: sh1_d = alu_a_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_op  <= alu_op_i;
      s1_tag <= tag_i;
      s1_a   <= alu_a_i;
      s1_b   <= alu_b_i;
      s1_sum <= sum_d;
      s1_sh  <= sh1_d;
    end
  end

  // Stage 2: coarse shift (multiples of 8), compares, final select
  assign amt_hi = s1_b[SHW-1:0] & ~LO_MASK;

  always_comb begin
    sh2 = s1_sh;
    case (s1_op)
      OP_SLL:  sh2 = s1_sh << amt_hi;
      OP_SRL:  sh2 = s1_sh >> amt_hi;
      OP_SRA:  sh2 = $signed(s1_sh) >>> amt_hi;
      default: sh2 = s1_sh;
    endcase
  end

  assign lt_u = s1_a < s1_b;
  assign gt_u = s1_b < s1_a;
  assign lt_s = $signed(s1_a) < $signed(s1_b);
  assign gt_s = $signed(s1_b) < $signed(s1_a);

  assign add_ovf = (s1_a[MSB] == s1_b[MSB]) &&
                   (s1_sum[MSB] != s1_a[MSB]);
  assign sub_ovf = (s1_a[MSB] != s1_b[MSB]) &&
                   (s1_sum[MSB] != s1_a[MSB]);

  always_comb begin
    res   = s1_a;
    ovf_d = 1'b0;
    case (s1_op)
      OP_SLL,
      OP_SRL,
      OP_SRA:  res = sh2;
      OP_ADD: begin
        res   = s1_sum;
        ovf_d = add_ovf;
      end
      OP_SUB: begin
        res   = s1_sum;
        ovf_d = sub_ovf;
      end
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      OP_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      OP_MINU: res = gt_u ? s1_b : s1_a;
      OP_MIN:  res = gt_s ? s1_b : s1_a;
      OP_MAXU: res = lt_u ? s1_b : s1_a;
      OP_MAX:  res = lt_s ? s1_b : s1_a;
      default: res = s1_a;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      alu_p_o  <= '0;
      tag_o    <= '0;
      zero_o   <= 1'b1;
      ovf_o    <= 1'b0;
    end else begin
      if (flush_i) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (in_ready_o) s1_valid <= in_valid_i;
        if (s2_adv)     s2_valid <= s1_valid;
      end
      if (s2_load) begin
        alu_p_o <= res;
        tag_o   <= s1_tag;
        zero_o  <= (res == '0);
        ovf_o   <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: vector table, stall/flush/reset
// sequences and random ops against a behavioural model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic [4:0]  tag_out;
  logic        zero;
  logic        ovf;

  alu_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .alu_op_i    (op),
    .alu_a_i     (a),
    .alu_b_i     (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_p_o     (p),
    .tag_o       (tag_out),
    .zero_o      (zero),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic [4:0]  tag;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t e_m;

  int errors   = 0;
  int checks   = 0;
  int xfer_cnt = 0;
  int rdy_mode = 0;

  logic        held = 1'b0;
  logic [31:0] held_p;
  logic [4:0]  held_tag;
  logic        held_z;
  logic        held_o;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic [4:0] t);
    exp_t        r;
    logic [63:0] ext;
    logic [4:0]  s;
    logic [31:0] xs;
    logic [31:0] ys;
    s     = y[4:0];
    xs    = x ^ 32'h8000_0000;
    ys    = y ^ 32'h8000_0000;
    r.p   = x;
    r.ovf = 1'b0;
    r.tag = t;
    case (o)
      4'd1: r.p = x << s;
      4'd2: r.p = x >> s;
      4'd3: begin
        ext = {{32{x[31]}}, x} >> s;
        r.p = ext[31:0];
      end
      4'd4: begin
        r.p   = x + y;
        r.ovf = (x[31] == y[31]) && (r.p[31] != x[31]);
      end
      4'd5: begin
        r.p   = x - y;
        r.ovf = (x[31] != y[31]) && (r.p[31] != x[31]);
      end
      4'd6:  r.p = x & y;
      4'd7:  r.p = x | y;
      4'd8:  r.p = x ^ y;
      4'd9:  r.p = (x < y) ? 32'd1 : 32'd0;
      4'd10: r.p = (xs < ys) ? 32'd1 : 32'd0;
      4'd11: r.p = (y < x) ? y : x;
      4'd12: r.p = (ys < xs) ? y : x;
      4'd13: r.p = (y > x) ? y : x;
      4'd14: r.p = (ys > xs) ? y : x;
      default: r.p = x;
    endcase
    r.zero = (r.p == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic add_vec(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] r,
                         input logic v);
    vec_t t;
    t.op  = o;
    t.a   = x;
    t.b   = y;
    t.p   = r;
    t.ovf = v;
    tbl.push_back(t);
  endtask

  // Drive one op, wait (bounded) for acceptance, record its expectation
  task automatic send(input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] t,
                      input exp_t e);
    int n;
    n        = 0;
    op       = o;
    a        = x;
    b        = y;
    tag      = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n        = 0;
    rdy_mode = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = ~out_ready;
    else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pop on transfer, stability under stall
  always @(negedge clk) begin
    if (rst || flush) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        if (out_valid)
          chk("stall_hold", 64'({p, tag_out, zero, ovf}),
              64'({held_p, held_tag, held_z, held_o}));
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got p=%0h tag=%0d, required none",
                   p, tag_out);
        end else begin
          e_m = sb.pop_front();
          chk("result", 64'(p), 64'(e_m.p));
          chk("tag_zero_ovf", 64'({tag_out, zero, ovf}),
              64'({e_m.tag, e_m.zero, e_m.ovf}));
        end
      end
      held     = out_valid && !out_ready;
      held_p   = p;
      held_tag = tag_out;
      held_z   = zero;
      held_o   = ovf;
    end
  end

  initial begin
    int c0;
    exp_t e;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;
    tag       = 5'd0;

    add_vec(4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    add_vec(4'd3,  32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 1'b0);
    add_vec(4'd2,  32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0);
    add_vec(4'd1,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0);
    add_vec(4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    add_vec(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    add_vec(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    add_vec(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec(4'd5,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);
    add_vec(4'd5,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    add_vec(4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    add_vec(4'd4,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    add_vec(4'd5,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    add_vec(4'd1,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0);
    add_vec(4'd3,  32'h0F00_0000, 32'h0000_0004, 32'h00F0_0000, 1'b0);
    add_vec(4'd3,  32'hF000_0000, 32'h0000_000C, 32'hFFFF_0000, 1'b0);
    add_vec(4'd2,  32'hF000_0000, 32'h0000_0009, 32'h0078_0000, 1'b0);
    add_vec(4'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    add_vec(4'd7,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    add_vec(4'd8,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    add_vec(4'd14, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0);
    add_vec(4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    add_vec(4'd12, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003, 1'b0);
    add_vec(4'd0,  32'h1234_5678, 32'h0000_0009, 32'h1234_5678, 1'b0);
    add_vec(4'd15, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    add_vec(4'd10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    add_vec(4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b0;

    // Latency: result visible two cycles after the op is offered
    @(posedge clk);
    #1;
    op       = 4'd4;
    a        = 32'h7FFF_FFFF;
    b        = 32'h0000_0001;
    tag      = 5'd9;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_accept", 64'(in_ready), 64'd1);
    e.p    = 32'h8000_0000;
    e.tag  = 5'd9;
    e.zero = 1'b0;
    e.ovf  = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_s1_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_s2_out_valid", 64'(out_valid), 64'd1);
    chk("lat_p", 64'(p), 64'h8000_0000);
    chk("lat_ovf", 64'(ovf), 64'd1);
    drain();

    // Vector table with sink always ready
    for (int i = 0; i < tbl.size(); i++) begin
      e.p    = tbl[i].p;
      e.tag  = 5'(i);
      e.zero = (tbl[i].p == 32'd0);
      e.ovf  = tbl[i].ovf;
      send(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i), e);
    end
    drain();

    // Back-to-back with sink toggling
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(4'd4, 32'(i * 3), 32'd100, 5'(i),
           model(4'd4, 32'(i * 3), 32'd100, 5'(i)));
    drain();

    // Fill both stages under stall, then release
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd8, 32'h0000_00FF, 32'h0000_0F0F, 5'd1,
         model(4'd8, 32'h0000_00FF, 32'h0000_0F0F, 5'd1));
    send(4'd5, 32'd10, 32'd3, 5'd2, model(4'd5, 32'd10, 32'd3, 5'd2));
    op       = 4'd6;
    a        = 32'hFFFF_0000;
    b        = 32'h00FF_FF00;
    tag      = 5'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    c0 = xfer_cnt;
    sb.push_back(model(4'd6, 32'hFFFF_0000, 32'h00FF_FF00, 5'd3));
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("drain_rate", 64'(xfer_cnt - c0), 64'd3);
    drain();

    // Flush with two ops in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd4, 32'd1, 32'd2, 5'd4, model(4'd4, 32'd1, 32'd2, 5'd4));
    send(4'd4, 32'd3, 32'd4, 5'd5, model(4'd4, 32'd3, 32'd4, 5'd5));
    flush    = 1'b1;
    op       = 4'd4;
    a        = 32'd7;
    b        = 32'd7;
    tag      = 5'd6;
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_blocks_in", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_idle", 64'(out_valid), 64'd0);
    send(4'd13, 32'd9, 32'd12, 5'd7, model(4'd13, 32'd9, 32'd12, 5'd7));
    drain();

    // Reset pulse mid-stream
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd1, 32'd1, 32'd4, 5'd8, model(4'd1, 32'd1, 32'd4, 5'd8));
    send(4'd1, 32'd1, 32'd5, 5'd9, model(4'd1, 32'd1, 32'd5, 5'd9));
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_p", 64'(p), 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", 64'(out_valid), 64'd0);
    send(4'd5, 32'd3, 32'd8, 5'd10, model(4'd5, 32'd3, 32'd8, 5'd10));
    drain();

    // Random ops against the model with a random sink
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 4'($urandom_range(0, 15));
      ra = rnd_val();
      rb = rnd_val();
      send(ro, ra, rb, 5'(i), model(ro, ra, rb, 5'(i)));
    end
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
